// File: rtl/mmio_port_controller.sv
// rtl/mmio_port_controller.sv - memory-mapped output port, debounced input port, change flag and cycle counter
module mmio_port_controller #(
  parameter logic [31:0] BASE_ADDR       = 32'h1001_0000,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic [31:0] PortOut,
  output logic        IrqChanged
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // The edge that would take the counter to DEBOUNCE_CYCLES is the one that commits.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] OFF_PORT_OUT = 2'd0;
  localparam logic [1:0] OFF_PORT_IN  = 2'd1;
  localparam logic [1:0] OFF_STATUS   = 2'd2;
  localparam logic [1:0] OFF_CYCLES   = 2'd3;

  logic [1:0]       word_sel;
  logic             wr_en;
  logic             wr_port_out;
  logic             wr_status;
  logic             wr_cycles;

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       debounced;
  logic [7:0]       debounced_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             fire;

  logic             changed;
  logic             changed_next;
  logic             irq_en;
  logic             irq_en_next;
  logic [31:0]      cycles;

  // Byte lane bits carry no meaning for word registers.
  logic             unused_addr_bits;
  assign unused_addr_bits = ^Address[1:0];

  assign Hit         = (Address[31:4] == BASE_ADDR[31:4]);
  assign word_sel    = Address[3:2];
  assign wr_en       = MemWrite && Hit;
  assign wr_port_out = wr_en && (word_sel == OFF_PORT_OUT);
  assign wr_status   = wr_en && (word_sel == OFF_STATUS);
  assign wr_cycles   = wr_en && (word_sel == OFF_CYCLES);

  // Debounce: count edges where sync2 holds steady at a value different from debounced.
  always_comb begin
    cnt_next       = '0;
    debounced_next = debounced;
    fire           = 1'b0;
    if ((sync1 == sync2) && (sync2 != debounced)) begin
      if (cnt == CNT_LAST) begin
        fire           = 1'b1;
        debounced_next = sync2;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // Status bits: a new change outranks a simultaneous write-1-to-clear.
  always_comb begin
    changed_next = fire | (changed & ~(wr_status & WriteData[0]));
    irq_en_next  = wr_status ? WriteData[1] : irq_en;
  end

  // Input synchroniser and debounce state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      debounced <= '0;
      cnt       <= '0;
    end else begin
      sync1     <= PortIn;
      sync2     <= sync1;
      debounced <= debounced_next;
      cnt       <= cnt_next;
    end
  end

  // Status register and the registered interrupt line derived from its next value.
  always_ff @(posedge clk) begin
    if (reset) begin
      changed    <= 1'b0;
      irq_en     <= 1'b0;
      IrqChanged <= 1'b0;
    end else begin
      changed    <= changed_next;
      irq_en     <= irq_en_next;
      IrqChanged <= changed_next && irq_en_next;
    end
  end

  // Output port latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      PortOut <= '0;
    end else if (wr_port_out) begin
      PortOut <= WriteData;
    end
  end

  // Free-running cycle counter; a store replaces that edge's increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles <= '0;
    end else if (wr_cycles) begin
      cycles <= WriteData;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  // Combinational read mux so a load completes in its own cycle.
  always_comb begin
    ReadData = '0;
    if (MemRead && Hit) begin
      case (word_sel)
        OFF_PORT_OUT: ReadData = PortOut;
        OFF_PORT_IN:  ReadData = {24'b0, debounced};
        OFF_STATUS:   ReadData = {30'b0, irq_en, changed};
        OFF_CYCLES:   ReadData = cycles;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_port_controller.sv
// tb/tb_mmio_port_controller.sv - scoreboard bench for mmio_port_controller
module tb_mmio_port_controller;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam logic [31:0] A_OUT = BASE;
  localparam logic [31:0] A_IN  = BASE + 32'h4;
  localparam logic [31:0] A_ST  = BASE + 32'h8;
  localparam logic [31:0] A_CYC = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [7:0]  PortIn;
  logic [31:0] ReadData;
  logic        Hit;
  logic [31:0] PortOut;
  logic        IrqChanged;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  mmio_port_controller #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .WriteData(WriteData), .PortIn(PortIn),
    .ReadData(ReadData), .Hit(Hit), .PortOut(PortOut), .IrqChanged(IrqChanged)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_bus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    MemRead   = rd;
    MemWrite  = wr;
    Address   = addr;
    WriteData = data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    PortIn = 8'h3C;
    set_bus(1'b0, 1'b1, A_CYC, 32'h55);
    tick();
    tick();
    reset = 1'b0;
    PortIn = 8'h00;
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      set_bus(1'b1, 1'b0, BASE + 32'(i * 4), 32'h0);
      exp_q.push_back((i == 3) ? 32'd2 : 32'd0);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (ReadData !== exp) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %h expected %h", i, ReadData, exp);
      end
    end
    checks++;
    if (PortOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_portout: got %h expected 00000000", PortOut);
    end
    checks++;
    if (IrqChanged !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", IrqChanged);
    end
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_port_out();
    set_bus(1'b0, 1'b1, A_OUT, 32'hDEAD_BEEF);
    tick();
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (PortOut !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL portout_store: got %h expected deadbeef", PortOut);
    end
    set_bus(1'b1, 1'b1, 32'h1002_0000, 32'h1234_5678);
    exp_q.push_back(32'h0);
    #1;
    checks++;
    if (Hit !== 1'b0) begin
      errors++;
      $display("FAIL miss_hit: got %b expected 0", Hit);
    end
    exp = exp_q.pop_front();
    checks++;
    if (ReadData !== exp) begin
      errors++;
      $display("FAIL miss_read: got %h expected %h", ReadData, exp);
    end
    tick();
    checks++;
    if (PortOut !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL miss_store: got %h expected deadbeef", PortOut);
    end
    // Simultaneous load and store on the same word, byte offset 3.
    set_bus(1'b1, 1'b1, BASE + 32'h3, 32'h0BAD_F00D);
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    checks++;
    if (Hit !== 1'b1) begin
      errors++;
      $display("FAIL hit_offset: got %b expected 1", Hit);
    end
    exp = exp_q.pop_front();
    checks++;
    if (ReadData !== exp) begin
      errors++;
      $display("FAIL rmw_read: got %h expected %h", ReadData, exp);
    end
    tick();
    checks++;
    if (PortOut !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL rmw_store: got %h expected 0badf00d", PortOut);
    end
    set_bus(1'b0, 1'b1, A_IN, 32'hFF);
    tick();
    set_bus(1'b1, 1'b0, A_IN, 32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (ReadData !== exp) begin
      errors++;
      $display("FAIL portin_readonly: got %h expected %h", ReadData, exp);
    end
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_glitch();
    set_bus(1'b1, 1'b0, A_IN, 32'h0);
    PortIn = 8'h01;
    tick();
    tick();
    tick();
    PortIn = 8'h00;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_q.push_back(32'h0);
      exp = exp_q.pop_front();
      checks++;
      if (ReadData !== exp) begin
        errors++;
        $display("FAIL glitch_portin[%0d]: got %h expected %h", k, ReadData, exp);
      end
    end
    set_bus(1'b1, 1'b0, A_ST, 32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (ReadData !== exp) begin
      errors++;
      $display("FAIL glitch_status: got %h expected %h", ReadData, exp);
    end
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_debounce();
    PortIn = 8'hA5;
    for (int k = 0; k <= 5; k++) begin
      tick();
      set_bus(1'b1, 1'b0, A_IN, 32'h0);
      exp_q.push_back((k == 5) ? 32'h0000_00A5 : 32'h0);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (ReadData !== exp) begin
        errors++;
        $display("FAIL debounce_portin[edge %0d]: got %h expected %h", k, ReadData, exp);
      end
      set_bus(1'b1, 1'b0, A_ST, 32'h0);
      exp_q.push_back((k == 5) ? 32'h1 : 32'h0);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (ReadData !== exp) begin
        errors++;
        $display("FAIL debounce_status[edge %0d]: got %h expected %h", k, ReadData, exp);
      end
    end
    tick();
    set_bus(1'b0, 1'b1, A_ST, 32'h1);
    tick();
    set_bus(1'b1, 1'b0, A_ST, 32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (ReadData !== exp) begin
      errors++;
      $display("FAIL changed_clear: got %h expected %h", ReadData, exp);
    end
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_irq();
    set_bus(1'b0, 1'b1, A_ST, 32'h2);
    tick();
    checks++;
    if (IrqChanged !== 1'b0) begin
      errors++;
      $display("FAIL irq_enable_only: got %b expected 0", IrqChanged);
    end
    PortIn = 8'h5A;
    set_bus(1'b1, 1'b0, A_ST, 32'h0);
    for (int k = 0; k <= 5; k++) begin
      tick();
      exp_q.push_back((k == 5) ? 32'h3 : 32'h2);
      exp = exp_q.pop_front();
      checks++;
      if (ReadData !== exp) begin
        errors++;
        $display("FAIL irq_status[edge %0d]: got %h expected %h", k, ReadData, exp);
      end
      checks++;
      if (IrqChanged !== (k == 5)) begin
        errors++;
        $display("FAIL irq_line[edge %0d]: got %b expected %b", k, IrqChanged, (k == 5));
      end
    end
    set_bus(1'b0, 1'b1, A_ST, 32'h3);
    tick();
    set_bus(1'b1, 1'b0, A_ST, 32'h0);
    exp_q.push_back(32'h2);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (ReadData !== exp) begin
      errors++;
      $display("FAIL irq_clear_status: got %h expected %h", ReadData, exp);
    end
    checks++;
    if (IrqChanged !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear_line: got %b expected 0", IrqChanged);
    end
    // Clear lands on the same edge as the next debounced change.
    PortIn = 8'hA5;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_q.push_back(32'h2);
      exp = exp_q.pop_front();
      checks++;
      if (ReadData !== exp) begin
        errors++;
        $display("FAIL race_pre_status[edge %0d]: got %h expected %h", k, ReadData, exp);
      end
    end
    set_bus(1'b1, 1'b1, A_ST, 32'h3);
    tick();
    set_bus(1'b1, 1'b0, A_ST, 32'h0);
    exp_q.push_back(32'h3);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (ReadData !== exp) begin
      errors++;
      $display("FAIL race_status: got %h expected %h", ReadData, exp);
    end
    checks++;
    if (IrqChanged !== 1'b1) begin
      errors++;
      $display("FAIL race_irq: got %b expected 1", IrqChanged);
    end
    set_bus(1'b1, 1'b0, A_IN, 32'h0);
    exp_q.push_back(32'h0000_00A5);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (ReadData !== exp) begin
      errors++;
      $display("FAIL race_portin: got %h expected %h", ReadData, exp);
    end
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_cycles();
    set_bus(1'b0, 1'b1, A_CYC, 32'hFFFF_FFFE);
    tick();
    set_bus(1'b1, 1'b0, A_CYC, 32'h0);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(32'hFFFF_FFFE + 32'(k));
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (ReadData !== exp) begin
        errors++;
        $display("FAIL cycles_wrap[%0d]: got %h expected %h", k, ReadData, exp);
      end
      tick();
    end
    reset = 1'b1;
    set_bus(1'b0, 1'b1, A_CYC, 32'h10);
    tick();
    reset = 1'b0;
    set_bus(1'b1, 1'b0, A_CYC, 32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (ReadData !== exp) begin
      errors++;
      $display("FAIL reset_over_write: got %h expected %h", ReadData, exp);
    end
    checks++;
    if (PortOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_portout_late: got %h expected 00000000", PortOut);
    end
    tick();
    exp_q.push_back(32'h1);
    exp = exp_q.pop_front();
    checks++;
    if (ReadData !== exp) begin
      errors++;
      $display("FAIL cycles_after_reset: got %h expected %h", ReadData, exp);
    end
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    PortIn = 8'h00;
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_port_out();
    test_glitch();
    test_debounce();
    test_irq();
    test_cycles();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
